// File: rtl/txframe_gen.sv
// txframe_gen: command-driven sensor frame generator.
// Fetches one channel (cmd < CH_NUM) or all channels (cmd == 8'hFF) from the
// sensor-data cache, then streams a response frame byte by byte:
//   DEV_ID[15:8], DEV_ID[7:0], CNT[15:8], CNT[7:0], payload..., CRC[7:0], CRC[15:8]
// Invalid commands (code E1) and cache timeouts (code E2) produce an error
// frame with CNT = 1 and the error code as the single payload byte.
// CRC is CRC-16/MODBUS over everything from DEV_ID[15:8] to the last payload byte.
//
// Ports:
//   sys_clk, sys_rst        clock (rising edge), async active-low reset
//   cmd, cmd_flag           command from parser, one-cycle strobe
//   busy                    frame in progress
//   req_cmd, req_cmd_flag   channel request to the cache
//   req_data, req_data_flag sample returned by the cache
//   bus_data, bus_data_flag byte to the transmitter, one-cycle strobe
//   bus_send_finish         transmitter done with the current byte
//   err_flag                pulse when an error frame starts
//
// state   | meaning
// IDLE    | waiting for cmd_flag
// REQ     | issue one cache request for the current channel
// WAIT    | waiting for the cache sample, timeout running
// HDR     | sending device ID and byte count
// PAY     | sending buffered samples, MSB first, channel order
// ERR_PAY | sending the single error-code byte
// CRC     | sending CRC low then high byte
module txframe_gen #(
  parameter logic [15:0] DEV_ID      = 16'h0001,
  parameter int          DATA_W      = 32,
  parameter int          CH_NUM      = 4,
  parameter int          REQ_TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [7:0]        cmd,
  input  logic              cmd_flag,
  output logic              busy,
  output logic [7:0]        req_cmd,
  output logic              req_cmd_flag,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_data_flag,
  output logic [7:0]        bus_data,
  output logic              bus_data_flag,
  input  logic              bus_send_finish,
  output logic              err_flag
);

  localparam int BW = DATA_W / 8;
  localparam int KW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int NW = $clog2(CH_NUM + 1);
  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(REQ_TIMEOUT - 1);
  localparam logic [2:0]    BW_LAST  = 3'(BW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HDR, S_PAY, S_CRC, S_ERR_PAY
  } state_t;

  state_t            r_state, w_next;
  logic              r_busy, r_req_flag, r_bus_flag, r_err_flag;
  logic [7:0]        r_req_cmd, r_bus_data, r_err_code, r_ch;
  logic              r_err;
  logic [NW-1:0]     r_nch;
  logic [KW-1:0]     r_k;
  logic [TW-1:0]     r_tmo;
  logic [2:0]        r_bidx;
  logic              r_pend;   // a byte must be presented on the next edge
  logic              r_out;    // a byte is on the bus awaiting bus_send_finish
  logic              r_last;   // the outstanding byte is the last of this state
  logic [15:0]       r_crc;
  logic [DATA_W-1:0] r_buf [CH_NUM];

  logic              w_cmd_ok, w_tmo, w_k_last, w_fin, w_issue, w_is_last;
  logic [7:0]        w_byte;
  logic [15:0]       w_cnt;
  logic [6:0]        w_shamt;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    return x;
  endfunction

  assign w_cmd_ok = (cmd < 8'(CH_NUM)) || (cmd == 8'hFF);
  assign w_tmo    = (r_tmo == TMO_LAST);
  assign w_k_last = ((NW'(r_k) + NW'(1)) == r_nch);
  assign w_fin    = bus_send_finish && r_out && r_last;
  assign w_cnt    = r_err ? 16'h0001 : (16'(r_nch) * 16'(BW));
  assign w_shamt  = 7'(DATA_W - 8) - {1'b0, r_bidx, 3'b000};

  // next-state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cmd_flag) w_next = w_cmd_ok ? S_REQ : S_HDR;
      S_REQ:     w_next = S_WAIT;
      S_WAIT: begin
        // sample beats timeout when both land in the same cycle
        if (req_data_flag) w_next = w_k_last ? S_HDR : S_REQ;
        else if (w_tmo)    w_next = S_HDR;
      end
      S_HDR:     if (w_fin) w_next = r_err ? S_ERR_PAY : S_PAY;
      S_PAY:     if (w_fin) w_next = S_CRC;
      S_ERR_PAY: if (w_fin) w_next = S_CRC;
      S_CRC:     if (w_fin) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // byte selection for the emitting states
  always_comb begin
    w_issue   = 1'b0;
    w_byte    = 8'h00;
    w_is_last = 1'b0;
    case (r_state)
      S_HDR: begin
        w_issue   = r_pend;
        w_is_last = (r_bidx == 3'd3);
        case (r_bidx[1:0])
          2'd0: w_byte = DEV_ID[15:8];
          2'd1: w_byte = DEV_ID[7:0];
          2'd2: w_byte = w_cnt[15:8];
          2'd3: w_byte = w_cnt[7:0];
        endcase
      end
      S_PAY: begin
        w_issue   = r_pend;
        w_is_last = (r_bidx == BW_LAST) && w_k_last;
        w_byte    = 8'(r_buf[r_k] >> w_shamt);
      end
      S_ERR_PAY: begin
        w_issue   = r_pend;
        w_is_last = 1'b1;
        w_byte    = r_err_code;
      end
      S_CRC: begin
        w_issue   = r_pend;
        w_is_last = r_bidx[0];
        w_byte    = r_bidx[0] ? r_crc[15:8] : r_crc[7:0];
      end
      default: ;
    endcase
  end

  // state register and registered datapath
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_req_cmd  <= 8'h00;
      r_req_flag <= 1'b0;
      r_bus_data <= 8'h00;
      r_bus_flag <= 1'b0;
      r_err_flag <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 8'h00;
      r_ch       <= 8'h00;
      r_nch      <= '0;
      r_k        <= '0;
      r_tmo      <= '0;
      r_bidx     <= 3'd0;
      r_pend     <= 1'b0;
      r_out      <= 1'b0;
      r_last     <= 1'b0;
      r_crc      <= 16'h0000;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != S_IDLE);
      r_req_flag <= 1'b0;
      r_bus_flag <= 1'b0;
      r_err_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bus_data <= 8'h00;
          if (cmd_flag) begin
            r_crc  <= 16'hFFFF;
            r_k    <= '0;
            r_bidx <= 3'd0;
            r_out  <= 1'b0;
            r_last <= 1'b0;
            if (w_cmd_ok) begin
              r_err <= 1'b0;
              r_ch  <= (cmd == 8'hFF) ? 8'h00 : cmd;
              r_nch <= (cmd == 8'hFF) ? NW'(CH_NUM) : NW'(1);
            end else begin
              r_err      <= 1'b1;
              r_err_code <= 8'hE1;
              r_err_flag <= 1'b1;
              r_pend     <= 1'b1;
            end
          end
        end
        S_REQ: begin
          r_req_cmd  <= r_ch;
          r_req_flag <= 1'b1;
          r_tmo      <= '0;
        end
        S_WAIT: begin
          if (req_data_flag) begin
            if (w_k_last) begin
              r_pend <= 1'b1;
            end else begin
              r_ch <= r_ch + 8'd1;
              r_k  <= r_k + 1'b1;
            end
          end else if (w_tmo) begin
            r_err      <= 1'b1;
            r_err_code <= 8'hE2;
            r_err_flag <= 1'b1;
            r_pend     <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          if (w_issue) begin
            r_bus_data <= w_byte;
            r_bus_flag <= 1'b1;
            r_out      <= 1'b1;
            r_pend     <= 1'b0;
            r_last     <= w_is_last;
            if (r_state != S_CRC) r_crc <= crc_upd(r_crc, w_byte);
            if (r_state == S_PAY && r_bidx == BW_LAST) begin
              r_bidx <= 3'd0;
              if (!w_k_last) r_k <= r_k + 1'b1;
            end else begin
              r_bidx <= r_bidx + 3'd1;
            end
          end else if (bus_send_finish && r_out) begin
            r_out <= 1'b0;
            if (r_last) begin
              // move on; the next state's first byte follows one cycle later
              r_last <= 1'b0;
              r_bidx <= 3'd0;
              r_k    <= '0;
              r_pend <= (r_state != S_CRC);
            end else begin
              r_pend <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // sample buffer has no reset; its contents are only read after being filled
  always_ff @(posedge sys_clk) begin
    if (r_state == S_WAIT && req_data_flag) r_buf[r_k] <= req_data;
  end

  assign busy          = r_busy;
  assign req_cmd       = r_req_cmd;
  assign req_cmd_flag  = r_req_flag;
  assign bus_data      = r_bus_data;
  assign bus_data_flag = r_bus_flag;
  assign err_flag      = r_err_flag;

endmodule

// File: doc/txframe_gen.md
Name: txframe_gen

Overview:
Parametrised successor to the single-sensor transmit-frame block. It accepts a command from the bus parser and fetches one channel, or all CH_NUM channels, from the sensor-data cache into an internal buffer. It then emits a framed response byte by byte to the UART/bus transmitter: device ID, byte count, payload (MSB first), and a real CRC-16/MODBUS. A request that times out, or names an invalid channel, produces an error frame instead.

Parameters:
DEV_ID, 16'h0001, device ID sent as the first two frame bytes (high byte first).
DATA_W, 32, bits per channel sample; multiple of 8, range 8..64.
CH_NUM, 4, number of sensor channels; range 1..16.
REQ_TIMEOUT, 255, cycles to wait for req_data_flag after req_cmd_flag before aborting.

Ports:
sys_clk  in  1  system clock, rising edge.
sys_rst  in  1  reset, asynchronous, active-low.
cmd  in  8  command from parser: 0..CH_NUM-1 = read one channel; 8'hFF = read all channels; any other value = invalid.
cmd_flag  in  1  one-cycle strobe, cmd valid.
busy  out  1  high from the cycle after an accepted cmd_flag until the last byte's bus_send_finish.
req_cmd  out  8  channel index requested from the cache.
req_cmd_flag  out  1  one-cycle request strobe.
req_data  in  DATA_W  returned sample.
req_data_flag  in  1  one-cycle strobe, req_data valid.
bus_data  out  8  byte to transmitter.
bus_data_flag  out  1  one-cycle strobe, bus_data valid.
bus_send_finish  in  1  one-cycle strobe, current byte transmitted.
err_flag  out  1  one-cycle pulse when an error frame is started.

Behaviour:
- Reset (sys_rst low, asynchronous) forces all outputs to 0, the state to IDLE, counters and CRC to 0, and the buffer contents to don't-care. Assertion mid-frame aborts immediately; no further bytes are emitted after release.
- States: IDLE, REQ, WAIT, HDR, PAY, CRC, ERR_PAY.
- IDLE:
  - cmd_flag with a valid cmd latches the mode (single or all), start channel and channel count (1 or CH_NUM), then goes to REQ.
  - An invalid cmd sets err code 8'hE1 and goes to HDR in error mode.
  - cmd_flag outside IDLE is ignored; the command is not queued.
- REQ: drives req_cmd = current channel and req_cmd_flag = 1 for exactly one cycle (registered, visible the cycle after entry), clears the timeout counter, then goes to WAIT.
- WAIT:
  - req_data_flag stores req_data into buffer slot k.
  - If more channels remain, go to REQ with channel+1; otherwise go to HDR in normal mode.
  - The timeout counter increments each cycle. On reaching REQ_TIMEOUT, set err code 8'hE2 and go to HDR in error mode.
  - If req_data_flag and the timeout occur in the same cycle, the data wins.
  - req_data_flag in any other state is ignored.
- Byte emission rule (HDR/PAY/ERR_PAY/CRC):
  - Each byte is a registered bus_data with a one-cycle bus_data_flag.
  - The first byte is presented 1 cycle after state entry.
  - Each following byte is presented 1 cycle after bus_send_finish is sampled high.
  - bus_send_finish is ignored when no byte is outstanding.
  - bus_data holds its value until the next byte; it returns to 0 in IDLE.
- HDR: sends 4 bytes: DEV_ID[15:8], DEV_ID[7:0], CNT[15:8], CNT[7:0].
  - Normal mode: CNT = nch*DATA_W/8 (single = DATA_W/8; all = CH_NUM*DATA_W/8).
  - Error mode: CNT = 16'h0001.
  - Then goes to PAY, or to ERR_PAY in error mode.
- PAY: sends buffer slots in channel order; within each slot, bytes go MSB first. The byte counter wraps from DATA_W/8-1 to 0 and advances the slot. After the last byte, go to CRC.
- ERR_PAY: sends the single err code byte, then goes to CRC. err_flag pulses in the cycle error mode is entered.
- CRC:
  - CRC-16/MODBUS: init 16'hFFFF, reflected polynomial 16'hA001, no final XOR, computed over every byte from DEV_ID[15:8] through the last payload byte.
  - The CRC register updates with each byte as its bus_data_flag is issued; a bytewise combinational 8-step update is permitted.
  - Sends CRC[7:0] then CRC[15:8]. The finish of the last byte returns to IDLE and drops busy in the same cycle.
  - A new cmd_flag is accepted on the cycle after IDLE is entered.

Test Plan:
- DEV_ID=16'h0102, DATA_W=32, cmd=8'h02, cache returns 32'hDEADBEEF 3 cycles after req_cmd_flag → req_cmd=8'h02 pulsed once; bytes 01 02 00 04 DE AD BE EF, then CRC low and high bytes matching a software CRC-16/MODBUS model; busy falls on the last finish.
- cmd=8'hFF, CH_NUM=4, samples 32'h00000001..32'h00000004 → 4 sequential requests for channels 0..3; CNT bytes 00 10; 16 payload bytes in channel order; correct CRC.
- cmd=8'h07 with CH_NUM=4 → no req_cmd_flag; err_flag pulse; bytes 01 02 00 01 E1 followed by CRC.
- No req_data_flag for REQ_TIMEOUT cycles during channel 1 of an all-channel read → error frame with code E2. Separately, req_data_flag arriving in the same cycle as the timeout → normal frame.
- Extra cmd_flag and stray bus_send_finish/req_data_flag pulses injected mid-frame → frame bytes unchanged and no extra requests; sys_rst pulsed low during PAY → all outputs 0 immediately and IDLE after release.
- CRC model check: the 9-byte sequence "123456789" fed through the CRC path yields 16'h4B37.
